// File: rtl/ram_ctrl.sv
// Sequencing master for a 256 x 16 single-port synchronous RAM: single reads/writes
// plus one-word-per-clock block scans and fills behind a start/busy/done handshake.
module ram_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  cmd,
   input  logic [7:0]  base_addr,
   input  logic [7:0]  count,
   input  logic [15:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic [15:0] rd_data,
   output logic [7:0]  rd_addr,
   output logic        rd_valid,
   output logic        ram_we,
   output logic [7:0]  ram_addr,
   output logic [15:0] ram_din,
   input  logic [15:0] ram_dout
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t      state, state_nxt;
   logic [8:0]  cnt, cnt_nxt;
   logic [8:0]  iss, iss_nxt;
   logic [8:0]  ret, ret_nxt;
   logic        vld_p1, vld_p1_nxt;
   logic [7:0]  addr_p1, addr_p1_nxt;
   logic        busy_nxt, done_nxt, rd_valid_nxt, ram_we_nxt;
   logic [15:0] rd_data_nxt, ram_din_nxt;
   logic [7:0]  rd_addr_nxt, ram_addr_nxt;

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      iss_nxt      = iss;
      ret_nxt      = ret;
      vld_p1_nxt   = 1'b0;
      addr_p1_nxt  = addr_p1;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      rd_valid_nxt = 1'b0;
      rd_data_nxt  = rd_data;
      rd_addr_nxt  = rd_addr;
      ram_we_nxt   = 1'b0;
      ram_addr_nxt = ram_addr;
      ram_din_nxt  = ram_din;
      case (state)
         IDLE: begin
            if (start) begin
               cnt_nxt      = cmd[1] ? ((count == 8'd0) ? 9'd256 : {1'b0, count}) : 9'd1;
               ram_addr_nxt = base_addr;
               busy_nxt     = 1'b1;
               ret_nxt      = 9'd0;
               if (cmd[0]) begin
                  state_nxt   = WRITE;
                  ram_we_nxt  = 1'b1;
                  ram_din_nxt = wr_data;
                  iss_nxt     = 9'd1;
               end else begin
                  state_nxt = READ;
                  iss_nxt   = 9'd0;
               end
            end
         end
         READ: begin
            // Stage p1: the RAM samples ram_addr at this edge; remember which address it was
            if (iss < cnt) begin
               iss_nxt     = iss + 9'd1;
               vld_p1_nxt  = 1'b1;
               addr_p1_nxt = ram_addr;
               if (iss + 9'd1 < cnt)
                  ram_addr_nxt = ram_addr + 8'd1;
            end
            // Stage p2: ram_dout now holds the word sampled one edge earlier
            if (vld_p1) begin
               rd_valid_nxt = 1'b1;
               rd_data_nxt  = ram_dout;
               rd_addr_nxt  = addr_p1;
               ret_nxt      = ret + 9'd1;
               if (ret + 9'd1 == cnt) begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
               end
            end
         end
         WRITE: begin
            if (iss < cnt) begin
               ram_we_nxt   = 1'b1;
               ram_addr_nxt = ram_addr + 8'd1;
               ram_din_nxt  = ram_din + 16'd1;
               iss_nxt      = iss + 9'd1;
            end else begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 9'd0;
         iss      <= 9'd0;
         ret      <= 9'd0;
         vld_p1   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= 16'd0;
         rd_addr  <= 8'd0;
         ram_we   <= 1'b0;
         ram_addr <= 8'd0;
         ram_din  <= 16'd0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         iss      <= iss_nxt;
         ret      <= ret_nxt;
         vld_p1   <= vld_p1_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         rd_valid <= rd_valid_nxt;
         rd_data  <= rd_data_nxt;
         rd_addr  <= rd_addr_nxt;
         ram_we   <= ram_we_nxt;
         ram_addr <= ram_addr_nxt;
         ram_din  <= ram_din_nxt;
      end
   end

   always_ff @(posedge clk) begin
      addr_p1 <= addr_p1_nxt;
   end

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: behavioural RAM, shadow memory model, directed and random commands.
module tb_ram_ctrl;

   logic        clk;
   logic        reset, start;
   logic [1:0]  cmd;
   logic [7:0]  base_addr, count;
   logic [15:0] wr_data;
   logic        busy, done, rd_valid, ram_we;
   logic [15:0] rd_data, ram_din, ram_dout;
   logic [7:0]  rd_addr, ram_addr;

   logic [15:0] mem [256];
   logic [15:0] ref_mem [256];
   int          nvec = 0;
   int          nerr = 0;

   ram_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .cmd(cmd),
      .base_addr(base_addr), .count(count), .wr_data(wr_data),
      .busy(busy), .done(done), .rd_data(rd_data), .rd_addr(rd_addr),
      .rd_valid(rd_valid), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one command and watch it cycle by cycle; observation c is taken after edge c.
   task automatic run_cmd(input logic [1:0] c_cmd, input logic [7:0] b, input logic [7:0] n8,
                          input logic [15:0] wd, input int inj, input int abort_rv);
      int n, c, busyw, we_n, we_first, we_last, we_err, rv_n, rv_first, rv_last;
      int done_n, done_c, stray;
      bit aborted;
      logic [7:0]  ea;
      logic [15:0] ed;
      n = c_cmd[1] ? ((n8 == 8'd0) ? 256 : int'(n8)) : 1;
      busyw = 0; we_n = 0; we_first = -1; we_last = -1; we_err = 0;
      rv_n = 0; rv_first = -1; rv_last = -1; done_n = 0; done_c = -1; stray = 0;
      aborted = 1'b0;
      check("idle_before_start", busy, 1'b0);
      cmd = c_cmd; base_addr = b; count = n8; wr_data = wd; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      base_addr = 8'($urandom); count = 8'($urandom); wr_data = 16'($urandom);
      c = 0;
      while (busy && c < 700) begin
         busyw++;
         if (ram_we) begin
            if (we_n == 0) we_first = c;
            we_last = c;
            ea = b + 8'(we_n);
            ed = wd + 16'(we_n);
            if (ram_addr !== ea || ram_din !== ed) we_err++;
            we_n++;
         end
         if (rd_valid) begin
            if (rv_n == 0) rv_first = c;
            rv_last = c;
            ea = b + 8'(rv_n);
            check("rd_addr", rd_addr, ea);
            check("rd_data", rd_data, ref_mem[ea]);
            rv_n++;
         end
         if (done) begin
            done_n++;
            done_c = c;
         end
         if (c == inj) begin
            start = 1'b1;
            cmd = 2'b01;
         end else start = 1'b0;
         if (abort_rv > 0 && rv_n == abort_rv && !aborted) begin
            reset = 1'b1;
            aborted = 1'b1;
         end else reset = 1'b0;
         @(negedge clk);
         c++;
      end
      start = 1'b0;
      reset = 1'b0;
      check("timeout_busy", busy, 1'b0);
      for (int k = 0; k < 3; k++) begin
         if (rd_valid || done || ram_we) stray++;
         @(negedge clk);
      end
      check("activity_after_idle", stray, 0);
      if (abort_rv > 0) begin
         check("abort_rv_count", rv_n, abort_rv);
         check("abort_done", done_n, 0);
         check("abort_outputs", {rd_addr, ram_addr, rd_data}, 32'd0);
      end else if (!c_cmd[0]) begin
         check("rv_count", rv_n, n);
         check("rv_first", rv_first, 2);
         check("rv_last", rv_last, n + 1);
         check("rd_done_count", done_n, 1);
         check("rd_done_cycle", done_c, n + 1);
         check("rd_busy_width", busyw, n + 2);
         check("rd_no_we", we_n, 0);
      end else begin
         check("we_count", we_n, n);
         check("we_first", we_first, 0);
         check("we_last", we_last, n - 1);
         check("we_words", we_err, 0);
         check("wr_done_count", done_n, 1);
         check("wr_done_cycle", done_c, n);
         check("wr_busy_width", busyw, n + 1);
         check("wr_no_rv", rv_n, 0);
         for (int i = 0; i < n; i++) ref_mem[8'(int'(b) + i)] = wd + 16'(i);
      end
   endtask

   initial begin
      logic [1:0]  rc;
      logic [7:0]  rb, rn;
      logic [15:0] rw;
      int          ri;
      for (int i = 0; i < 256; i++) ref_mem[i] = 16'd0;
      reset = 1'b1; start = 1'b0; cmd = 2'b00; base_addr = 8'd0; count = 8'd0; wr_data = 16'd0;
      repeat (2) @(negedge clk);
      check("reset_ctl", {busy, done, rd_valid, ram_we}, 32'd0);
      check("reset_addr", {rd_addr, ram_addr}, 32'd0);
      check("reset_data", {rd_data, ram_din}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // full memory fill and scan
      run_cmd(2'b11, 8'h00, 8'd0, 16'h1000, -1, 0);
      run_cmd(2'b10, 8'h00, 8'd0, 16'h0000, -1, 0);

      // reset held two cycles in the middle of a fill
      cmd = 2'b11; base_addr = 8'h80; count = 8'd10; wr_data = 16'h5A00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("midfill_rst_ctl", {busy, done, rd_valid, ram_we}, 32'd0);
      check("midfill_rst_addr", {rd_addr, ram_addr}, 32'd0);
      check("midfill_rst_data", {rd_data, ram_din}, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) ref_mem[8'h80 + i] = 16'h5A00 + 16'(i);
      run_cmd(2'b00, 8'h82, 8'd0, 16'h0000, -1, 0);
      run_cmd(2'b10, 8'h80, 8'd10, 16'h0000, -1, 0);

      // single write then single read
      run_cmd(2'b01, 8'h3C, 8'd7, 16'hBEEF, -1, 0);
      run_cmd(2'b00, 8'h3C, 8'd7, 16'h0000, -1, 0);

      // fill and scan across the address and data wrap
      run_cmd(2'b11, 8'hFE, 8'd4, 16'hFFFE, -1, 0);
      run_cmd(2'b10, 8'hFE, 8'd4, 16'h0000, -1, 0);

      // start with a write command while a scan is busy
      run_cmd(2'b10, 8'h10, 8'd8, 16'h0000, 3, 0);

      // reset after the third word of a scan, then a clean rescan
      run_cmd(2'b10, 8'h20, 8'd10, 16'h0000, -1, 3);
      run_cmd(2'b10, 8'h20, 8'd10, 16'h0000, -1, 0);

      for (int t = 0; t < 24; t++) begin
         rc = 2'($urandom_range(0, 3));
         rb = 8'($urandom);
         rn = 8'($urandom_range(0, 12));
         rw = 16'($urandom);
         ri = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1)) : -1;
         run_cmd(rc, rb, rn, rw, ri, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
